// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: sequences a W-bit falling-edge JK bank through clear/load/count commands.
// Optional shadow-register self-check is enabled by defining JK_CTRL_VERIFY_EN.
module jk_counter_ctrl #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_steps,
    input  logic [W-1:0]  q_in,
    output logic [W-1:0]  j,
    output logic [W-1:0]  k,
    output logic          ff_set_n,
    output logic          ff_reset_n,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COUNT, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          dn_q;
    logic          dn;
    logic [W-1:0]  mask;
    logic [W-1:0]  j_q;
    logic [W-1:0]  k_q;
    logic          rn_q;
    logic          busy_q;
    logic          done_q;

    assign cmd_ready  = state_q == IDLE;
    assign dn         = cmd_ready ? cmd_op[0] : dn_q;
    assign j          = j_q;
    assign k          = k_q;
    assign ff_set_n   = 1'b1;
    assign ff_reset_n = rn_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Toggle mask: a bit flips when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        mask    = '0;
        mask[0] = 1'b1;
        for (int i = 1; i < W; i++)
            mask[i] = mask[i-1] & (dn ? ~q_in[i-1] : q_in[i-1]);
    end

    // Command FSM with registered bank drive; each output defaults to the idle drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dn_q    <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            rn_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            j_q    <= '0;
            k_q    <= '0;
            rn_q   <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    busy_q <= 1'b1;
                    dn_q   <= cmd_op[0];
                    cnt_q  <= cmd_steps - CW'(1);
                    case (cmd_op)
                        2'b00: begin
                            state_q <= CLEAR;
                            rn_q    <= 1'b0;
                        end
                        2'b01: begin
                            state_q <= LOAD;
                            j_q     <= cmd_data;
                            k_q     <= ~cmd_data;
                        end
                        default: if (cmd_steps == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= COUNT;
                            j_q     <= mask;
                            k_q     <= mask;
                        end
                    endcase
                end
                CLEAR, LOAD: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                COUNT: if (cnt_q == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                    j_q   <= mask;
                    k_q   <= mask;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef JK_CTRL_VERIFY_EN
    logic [W-1:0] shadow_q;
    logic         err_q;

    assign err = err_q;

    // Shadow holds the value the bank should show after the action just driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state_q == CLEAR || state_q == LOAD || state_q == COUNT) && q_in != shadow_q)
                err_q <= 1'b1;
            if (cmd_ready && cmd_valid)
                shadow_q <= cmd_op == 2'b00 ? '0 :
                            cmd_op == 2'b01 ? cmd_data :
                            cmd_op[0] ? q_in - W'(1) : q_in + W'(1);
            else if (state_q == COUNT && cnt_q != '0)
                shadow_q <= dn_q ? shadow_q - W'(1) : shadow_q + W'(1);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
